// File: rtl/alu_dispatch.sv
// RV32I issue stage: decodes OP/OP-IMM/LUI/AUIPC into an ALU function code and
// operand pair, delivered through a 2-entry elastic buffer with registered ready.
module alu_dispatch #(
    parameter int DataWidth = 32,
    parameter int FuncWidth = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [DataWidth-1:0] pc,
    input  logic [DataWidth-1:0] rs1_data,
    input  logic [DataWidth-1:0] rs2_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FuncWidth-1:0] func,
    output logic [DataWidth-1:0] op1,
    output logic [DataWidth-1:0] op2,
    output logic [4:0]           rd,
    output logic                 illegal
);

    localparam logic [FuncWidth-1:0] F_ZERO = FuncWidth'(0);
    localparam logic [FuncWidth-1:0] F_ADD  = FuncWidth'(1);
    localparam logic [FuncWidth-1:0] F_SUB  = FuncWidth'(2);
    localparam logic [FuncWidth-1:0] F_SLL  = FuncWidth'(3);
    localparam logic [FuncWidth-1:0] F_SLT  = FuncWidth'(4);
    localparam logic [FuncWidth-1:0] F_XOR  = FuncWidth'(5);
    localparam logic [FuncWidth-1:0] F_OR   = FuncWidth'(6);
    localparam logic [FuncWidth-1:0] F_AND  = FuncWidth'(7);
    localparam logic [FuncWidth-1:0] F_SRL  = FuncWidth'(8);
    localparam logic [FuncWidth-1:0] F_SRA  = FuncWidth'(9);
    localparam logic [FuncWidth-1:0] F_SLTU = FuncWidth'(10);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    // Base function for a funct3 value; SUB/SRA are selected separately by funct7.
    function automatic logic [FuncWidth-1:0] f3_code(input logic [2:0] f3);
        case (f3)
            3'b000:  f3_code = F_ADD;
            3'b001:  f3_code = F_SLL;
            3'b010:  f3_code = F_SLT;
            3'b011:  f3_code = F_SLTU;
            3'b100:  f3_code = F_XOR;
            3'b101:  f3_code = F_SRL;
            3'b110:  f3_code = F_OR;
            default: f3_code = F_AND;
        endcase
    endfunction

    logic [6:0]           opcode;
    logic [2:0]           f3;
    logic [6:0]           f7;
    logic [DataWidth-1:0] imm_i;
    logic [DataWidth-1:0] imm_u;
    logic [DataWidth-1:0] shamt;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{(DataWidth-12){instr[31]}}, instr[31:20]};
    assign imm_u  = DataWidth'({instr[31:12], 12'b0});
    assign shamt  = DataWidth'(instr[24:20]);

    logic                 ok;
    logic [FuncWidth-1:0] fn;
    logic [DataWidth-1:0] a;
    logic [DataWidth-1:0] b;

    logic [FuncWidth-1:0] dec_func_p0;
    logic [DataWidth-1:0] dec_op1_p0;
    logic [DataWidth-1:0] dec_op2_p0;
    logic [4:0]           dec_rd_p0;
    logic                 dec_illegal_p0;

    // Stage p0: combinational decode of the incoming instruction.
    always_comb begin
        ok = 1'b0;
        fn = f3_code(f3);
        a  = rs1_data;
        b  = rs2_data;
        case (opcode)
            OPC_OP: begin
                ok = (f7 == F7_ZERO) ||
                     ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
                if (f7 == F7_ALT) fn = (f3 == 3'b000) ? F_SUB : F_SRA;
            end
            OPC_IMM: begin
                b = imm_i;
                if (f3 == 3'b001) begin
                    ok = (f7 == F7_ZERO);
                    b  = shamt;
                end else if (f3 == 3'b101) begin
                    ok = (f7 == F7_ZERO) || (f7 == F7_ALT);
                    b  = shamt;
                    if (f7 == F7_ALT) fn = F_SRA;
                end else begin
                    ok = 1'b1;
                end
            end
            OPC_LUI: begin
                ok = 1'b1;
                fn = F_ADD;
                a  = '0;
                b  = imm_u;
            end
            OPC_AUIPC: begin
                ok = 1'b1;
                fn = F_ADD;
                a  = pc;
                b  = imm_u;
            end
            default: ok = 1'b0;
        endcase

        dec_func_p0    = F_ZERO;
        dec_op1_p0     = '0;
        dec_op2_p0     = '0;
        dec_rd_p0      = '0;
        dec_illegal_p0 = 1'b1;
        if (ok) begin
            dec_func_p0    = fn;
            dec_op1_p0     = a;
            dec_op2_p0     = b;
            dec_rd_p0      = instr[11:7];
            dec_illegal_p0 = 1'b0;
        end
    end

    logic [1:0] count;
    logic [1:0] count_nxt;
    logic       push;
    logic       pop;
    logic       load_head;
    logic       load_spare;
    logic       shift_up;

    assign out_valid  = (count != 2'd0);
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    assign load_head  = push & ((count == 2'd0) | pop);
    assign load_spare = push & ~pop & (count == 2'd1);
    assign shift_up   = pop & ~push & (count == 2'd2);

    always_comb begin
        count_nxt = count;
        if (push && !pop)      count_nxt = count + 2'd1;
        else if (pop && !push) count_nxt = count - 2'd1;
    end

    logic [FuncWidth-1:0] spare_func_p1;
    logic [DataWidth-1:0] spare_op1_p1;
    logic [DataWidth-1:0] spare_op2_p1;
    logic [4:0]           spare_rd_p1;
    logic                 spare_illegal_p1;

    // Stage p1: second buffer slot, only ever refilled from the decoder.
    always_ff @(posedge clk) begin
        if (load_spare) begin
            spare_func_p1    <= dec_func_p0;
            spare_op1_p1     <= dec_op1_p0;
            spare_op2_p1     <= dec_op2_p0;
            spare_rd_p1      <= dec_rd_p0;
            spare_illegal_p1 <= dec_illegal_p0;
        end
    end

    // Head slot drives the outputs; ready is registered from the next occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= 2'd0;
            in_ready <= 1'b1;
            func     <= F_ZERO;
            op1      <= '0;
            op2      <= '0;
            rd       <= '0;
            illegal  <= 1'b0;
        end else begin
            count    <= count_nxt;
            in_ready <= (count_nxt != 2'd2);
            if (load_head) begin
                func    <= dec_func_p0;
                op1     <= dec_op1_p0;
                op2     <= dec_op2_p0;
                rd      <= dec_rd_p0;
                illegal <= dec_illegal_p0;
            end else if (shift_up) begin
                func    <= spare_func_p1;
                op1     <= spare_op1_p1;
                op2     <= spare_op2_p1;
                rd      <= spare_rd_p1;
                illegal <= spare_illegal_p1;
            end
        end
    end

endmodule
